// File: rtl/sm3_msg_expand_if.sv
// sm3_msg_expand_if
// Handshake bundle between the SM3 padding unit, the message-expansion
// stage and the compression round.
//   blk_valid_i / blk_ready_o / blk_i : upstream 512-bit block handshake
//   w_valid_o / w_ready_i             : downstream per-round handshake
//   w_o, wp_o                         : W_j and W'_j = W_j ^ W_{j+4}
//   round_o, last_o                   : current round index, high at round 63
//   busy_o                            : a block is being expanded
// The slave modport is the expansion stage; the master modport is its
// surroundings (padding unit upstream plus compression round downstream).
interface sm3_msg_expand_if;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [511:0] blk_i;
    logic         w_valid_o;
    logic         w_ready_i;
    logic [31:0]  w_o;
    logic [31:0]  wp_o;
    logic [5:0]   round_o;
    logic         last_o;
    logic         busy_o;

    modport slave (
        input  blk_valid_i, blk_i, w_ready_i,
        output blk_ready_o, w_valid_o, w_o, wp_o, round_o, last_o, busy_o
    );

    modport master (
        output blk_valid_i, blk_i, w_ready_i,
        input  blk_ready_o, w_valid_o, w_o, wp_o, round_o, last_o, busy_o
    );
endinterface

// File: rtl/sm3_msg_expand.sv
// sm3_msg_expand
// SM3 message expansion. Accepts one padded 512-bit block and streams the
// 64 word pairs (W_j, W'_j) to the compression round, one round per
// downstream handshake. A 16-word sliding window holds W_j..W_{j+15}; each
// handshake shifts it by one and appends the next expanded word.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     sm3_msg_expand_if.slave (block input, word output, status)
module sm3_msg_expand (
    input  logic            clk_i,
    input  logic            rst_ni,
    sm3_msg_expand_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] win [16];
    logic [5:0]  round;
    logic [31:0] next_word;
    logic        blk_ready_r;
    logic        w_valid_r;
    logic        busy_r;
    logic        last_r;

    function automatic logic [31:0] rotl7(input logic [31:0] x);
        return {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] rotl15(input logic [31:0] x);
        return {x[16:0], x[31:17]};
    endfunction

    function automatic logic [31:0] rotl23(input logic [31:0] x);
        return {x[8:0], x[31:9]};
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl15(x) ^ rotl23(x);
    endfunction

    // With win[k] = W_{j+k}, the word appended on this handshake is W_{j+16},
    // built from W_j, W_{j+7}, W_{j+13}, W_{j+3} and W_{j+10}.
    always_comb begin
        next_word = p1(win[0] ^ win[7] ^ rotl15(win[13])) ^ rotl7(win[3]) ^ win[10];
    end

    // Control FSM, window and round counter. Status outputs are flops so
    // nothing on the interface depends combinationally on the handshakes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            round       <= '0;
            blk_ready_r <= 1'b1;
            w_valid_r   <= 1'b0;
            busy_r      <= 1'b0;
            last_r      <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                win[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.blk_valid_i) begin
                        for (int k = 0; k < 16; k++) begin
                            win[k] <= bus.blk_i[511 - 32*k -: 32];
                        end
                        round       <= '0;
                        state       <= RUN;
                        blk_ready_r <= 1'b0;
                        w_valid_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        last_r      <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.w_ready_i) begin
                        for (int k = 0; k < 15; k++) begin
                            win[k] <= win[k+1];
                        end
                        win[15] <= next_word;
                        // Wraps 63 -> 0, so the counter is already cleared for
                        // the next block when leaving RUN.
                        round   <= round + 6'd1;
                        if (round == 6'd63) begin
                            state       <= IDLE;
                            blk_ready_r <= 1'b1;
                            w_valid_r   <= 1'b0;
                            busy_r      <= 1'b0;
                            last_r      <= 1'b0;
                        end else begin
                            last_r <= (round == 6'd62);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.blk_ready_o = blk_ready_r;
    assign bus.w_valid_o   = w_valid_r;
    assign bus.busy_o      = busy_r;
    assign bus.last_o      = last_r;
    assign bus.round_o     = round;
    assign bus.w_o         = win[0];
    // W'_j = W_j ^ W_{j+4}; the window always holds W_{j+4} in slot 4.
    assign bus.wp_o        = win[0] ^ win[4];
endmodule

// File: tb/tb_sm3_msg_expand.sv
// tb_sm3_msg_expand
// Directed bench for sm3_msg_expand: reset values, the "abc" block, random
// downstream stalls, back-to-back blocks, mid-block reset, all-zeros and
// all-ones blocks, and a long stall on the last round.
module tb_sm3_msg_expand;
    logic clk_i = 1'b0;
    logic rst_ni;

    sm3_msg_expand_if bus();

    sm3_msg_expand dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]  ref_w     [68];
    logic [31:0]  obs_w     [64];
    logic [31:0]  obs_wp    [64];
    logic [5:0]   obs_round [64];
    logic         obs_valid [64];
    logic         obs_last  [64];
    logic         obs_ready [64];
    logic [511:0] abc_blk;
    logic [31:0]  abc16 [8] = '{32'h9092e200, 32'h00000000, 32'h000c0606, 32'h719c70ed,
                                32'h00000000, 32'h8001801f, 32'h939f7da9, 32'h00000000};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // Reference expansion in textbook form over the full W array.
    task automatic compute_ref(input logic [511:0] b);
        for (int j = 0; j < 16; j++) ref_w[j] = b[511 - 32*j -: 32];
        for (int j = 16; j < 68; j++)
            ref_w[j] = p1(ref_w[j-16] ^ ref_w[j-9] ^ rotl(ref_w[j-3], 15))
                       ^ rotl(ref_w[j-13], 7) ^ ref_w[j-6];
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_block(input logic [511:0] b, output bit accepted);
        accepted        = 1'b0;
        bus.blk_i       = b;
        bus.blk_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (bus.blk_ready_o === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            step();
        end
        step();
        bus.blk_valid_i = 1'b0;
    endtask

    // Records 64 consecutive cycles with w_ready_i held high.
    task automatic capture_block();
        for (int j = 0; j < 64; j++) begin
            obs_w[j]     = bus.w_o;
            obs_wp[j]    = bus.wp_o;
            obs_round[j] = bus.round_o;
            obs_valid[j] = bus.w_valid_o;
            obs_last[j]  = bus.last_o;
            obs_ready[j] = bus.blk_ready_o;
            step();
        end
    endtask

    task automatic test_reset();
        rst_ni          = 1'b0;
        bus.blk_valid_i = 1'b0;
        bus.blk_i       = '0;
        bus.w_ready_i   = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (bus.blk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_blk_ready: got %b, want 1", bus.blk_ready_o); end
        n_cmp++; if (bus.w_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_w_valid: got %b, want 0", bus.w_valid_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, want 0", bus.busy_o); end
        n_cmp++; if (bus.last_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last: got %b, want 0", bus.last_o); end
        n_cmp++; if (bus.round_o !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_round: got %0d, want 0", bus.round_o); end
        n_cmp++; if (bus.w_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_w: got %h, want 0", bus.w_o); end
        n_cmp++; if (bus.wp_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wp: got %h, want 0", bus.wp_o); end
        rst_ni = 1'b1;
        step();
        n_cmp++; if (bus.blk_ready_o !== 1'b1 || bus.w_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL idle_after_reset: got ready=%b valid=%b, want ready=1 valid=0", bus.blk_ready_o, bus.w_valid_o);
        end
    endtask

    task automatic test_abc();
        bit acc;
        compute_ref(abc_blk);
        bus.w_ready_i = 1'b1;
        send_block(abc_blk, acc);
        n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL abc_accept: got %b, want 1", acc); end
        capture_block();
        n_cmp++; if (obs_w[0] !== 32'h61626380) begin n_fail++; $display("[TB] FAIL abc_w0: got %h, want 61626380", obs_w[0]); end
        n_cmp++; if (obs_wp[0] !== 32'h61626380) begin n_fail++; $display("[TB] FAIL abc_wp0: got %h, want 61626380", obs_wp[0]); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (obs_w[16+i] !== abc16[i]) begin n_fail++; $display("[TB] FAIL abc_w%0d: got %h, want %h", 16+i, obs_w[16+i], abc16[i]); end
        end
        for (int j = 0; j < 64; j++) begin
            n_cmp++; if (obs_w[j] !== ref_w[j]) begin n_fail++; $display("[TB] FAIL abc_w[%0d]: got %h, want %h", j, obs_w[j], ref_w[j]); end
            n_cmp++; if (obs_wp[j] !== (ref_w[j] ^ ref_w[j+4])) begin n_fail++; $display("[TB] FAIL abc_wp[%0d]: got %h, want %h", j, obs_wp[j], ref_w[j] ^ ref_w[j+4]); end
            n_cmp++; if (obs_round[j] !== 6'(j)) begin n_fail++; $display("[TB] FAIL abc_round[%0d]: got %0d, want %0d", j, obs_round[j], j); end
            n_cmp++; if (obs_valid[j] !== 1'b1) begin n_fail++; $display("[TB] FAIL abc_valid[%0d]: got %b, want 1", j, obs_valid[j]); end
            n_cmp++; if (obs_last[j] !== (j == 63)) begin n_fail++; $display("[TB] FAIL abc_last[%0d]: got %b, want %b", j, obs_last[j], (j == 63)); end
            n_cmp++; if (obs_ready[j] !== 1'b0) begin n_fail++; $display("[TB] FAIL abc_blk_ready[%0d]: got %b, want 0", j, obs_ready[j]); end
        end
        n_cmp++; if (bus.blk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL abc_ready_at_65: got %b, want 1", bus.blk_ready_o); end
        n_cmp++; if (bus.w_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.last_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abc_idle_status: got valid=%b busy=%b last=%b, want 0 0 0", bus.w_valid_o, bus.busy_o, bus.last_o);
        end
    endtask

    task automatic test_stall();
        bit          acc;
        int          idx;
        int          cyc;
        bit          stalled;
        logic [31:0] prev_w;
        logic [31:0] prev_wp;
        logic [5:0]  prev_round;
        compute_ref(abc_blk);
        bus.w_ready_i = 1'b1;
        send_block(abc_blk, acc);
        n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_accept: got %b, want 1", acc); end
        idx = 0; cyc = 0; stalled = 1'b0;
        prev_w = '0; prev_wp = '0; prev_round = '0;
        while (idx < 64 && cyc < 1000) begin
            n_cmp++; if (bus.w_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid[%0d]: got %b, want 1", idx, bus.w_valid_o); end
            n_cmp++; if (bus.round_o !== 6'(idx)) begin n_fail++; $display("[TB] FAIL stall_round: got %0d, want %0d", bus.round_o, idx); end
            n_cmp++; if (bus.w_o !== ref_w[idx]) begin n_fail++; $display("[TB] FAIL stall_w[%0d]: got %h, want %h", idx, bus.w_o, ref_w[idx]); end
            n_cmp++; if (bus.wp_o !== (ref_w[idx] ^ ref_w[idx+4])) begin n_fail++; $display("[TB] FAIL stall_wp[%0d]: got %h, want %h", idx, bus.wp_o, ref_w[idx] ^ ref_w[idx+4]); end
            n_cmp++; if (bus.last_o !== (idx == 63)) begin n_fail++; $display("[TB] FAIL stall_last[%0d]: got %b, want %b", idx, bus.last_o, (idx == 63)); end
            if (stalled) begin
                n_cmp++; if (bus.w_o !== prev_w || bus.wp_o !== prev_wp || bus.round_o !== prev_round) begin
                    n_fail++; $display("[TB] FAIL stall_hold: got %h/%h/%0d, want %h/%h/%0d", bus.w_o, bus.wp_o, bus.round_o, prev_w, prev_wp, prev_round);
                end
            end
            prev_w = bus.w_o; prev_wp = bus.wp_o; prev_round = bus.round_o;
            bus.w_ready_i = 1'($urandom_range(0, 1));
            stalled = !bus.w_ready_i;
            if (bus.w_ready_i) idx++;
            step();
            cyc++;
        end
        bus.w_ready_i = 1'b1;
        n_cmp++; if (idx != 64) begin n_fail++; $display("[TB] FAIL stall_timeout: got %0d rounds, want 64", idx); end
        n_cmp++; if (bus.blk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_end_ready: got %b, want 1", bus.blk_ready_o); end
    endtask

    task automatic test_back_to_back();
        logic [511:0] b1;
        logic [511:0] b2;
        rand_block(b1);
        rand_block(b2);
        compute_ref(b1);
        bus.w_ready_i   = 1'b1;
        bus.blk_i       = b1;
        bus.blk_valid_i = 1'b1;
        n_cmp++; if (bus.blk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready_first: got %b, want 1", bus.blk_ready_o); end
        step();
        bus.blk_i = b2;
        capture_block();
        for (int j = 0; j < 64; j++) begin
            n_cmp++; if (obs_w[j] !== ref_w[j] || obs_wp[j] !== (ref_w[j] ^ ref_w[j+4])) begin
                n_fail++; $display("[TB] FAIL b2b_blk1[%0d]: got %h/%h, want %h/%h", j, obs_w[j], obs_wp[j], ref_w[j], ref_w[j] ^ ref_w[j+4]);
            end
            n_cmp++; if (obs_round[j] !== 6'(j)) begin n_fail++; $display("[TB] FAIL b2b_round1[%0d]: got %0d, want %0d", j, obs_round[j], j); end
        end
        n_cmp++; if (bus.blk_ready_o !== 1'b1 || bus.w_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b_gap: got ready=%b valid=%b, want ready=1 valid=0", bus.blk_ready_o, bus.w_valid_o);
        end
        compute_ref(b2);
        step();
        bus.blk_valid_i = 1'b0;
        n_cmp++; if (bus.w_valid_o !== 1'b1 || bus.round_o !== 6'd0) begin
            n_fail++; $display("[TB] FAIL b2b_accept2: got valid=%b round=%0d, want valid=1 round=0", bus.w_valid_o, bus.round_o);
        end
        capture_block();
        for (int j = 0; j < 64; j++) begin
            n_cmp++; if (obs_w[j] !== ref_w[j] || obs_wp[j] !== (ref_w[j] ^ ref_w[j+4])) begin
                n_fail++; $display("[TB] FAIL b2b_blk2[%0d]: got %h/%h, want %h/%h", j, obs_w[j], obs_wp[j], ref_w[j], ref_w[j] ^ ref_w[j+4]);
            end
        end
        n_cmp++; if (bus.blk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_end_ready: got %b, want 1", bus.blk_ready_o); end
    endtask

    task automatic test_reset_mid();
        bit           acc;
        logic [511:0] b;
        compute_ref(abc_blk);
        bus.w_ready_i = 1'b1;
        send_block(abc_blk, acc);
        repeat (30) step();
        n_cmp++; if (bus.round_o !== 6'd30) begin n_fail++; $display("[TB] FAIL rmid_round30: got %0d, want 30", bus.round_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (bus.blk_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_blk_ready: got %b, want 1", bus.blk_ready_o); end
        n_cmp++; if (bus.w_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_w_valid: got %b, want 0", bus.w_valid_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_busy: got %b, want 0", bus.busy_o); end
        n_cmp++; if (bus.round_o !== 6'd0) begin n_fail++; $display("[TB] FAIL rmid_round: got %0d, want 0", bus.round_o); end
        n_cmp++; if (bus.w_o !== 32'h0 || bus.wp_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rmid_words: got %h/%h, want 0/0", bus.w_o, bus.wp_o); end
        step();
        rst_ni = 1'b1;
        rand_block(b);
        compute_ref(b);
        send_block(b, acc);
        n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_accept: got %b, want 1", acc); end
        capture_block();
        for (int j = 0; j < 64; j++) begin
            n_cmp++; if (obs_round[j] !== 6'(j) || obs_w[j] !== ref_w[j] || obs_wp[j] !== (ref_w[j] ^ ref_w[j+4])) begin
                n_fail++; $display("[TB] FAIL rmid_after[%0d]: got r=%0d %h/%h, want r=%0d %h/%h", j, obs_round[j], obs_w[j], obs_wp[j], j, ref_w[j], ref_w[j] ^ ref_w[j+4]);
            end
        end
    endtask

    task automatic test_zeros_ones();
        bit           acc;
        logic [511:0] ones;
        ones = '1;
        bus.w_ready_i = 1'b1;
        send_block('0, acc);
        capture_block();
        for (int j = 0; j < 64; j++) begin
            n_cmp++; if (obs_w[j] !== 32'h0 || obs_wp[j] !== 32'h0) begin
                n_fail++; $display("[TB] FAIL zeros[%0d]: got %h/%h, want 0/0", j, obs_w[j], obs_wp[j]);
            end
        end
        compute_ref(ones);
        send_block(ones, acc);
        capture_block();
        n_cmp++; if (obs_w[16] !== 32'hffffffff) begin n_fail++; $display("[TB] FAIL ones_w16: got %h, want ffffffff", obs_w[16]); end
        n_cmp++; if (obs_wp[0] !== 32'h0) begin n_fail++; $display("[TB] FAIL ones_wp0: got %h, want 0", obs_wp[0]); end
        for (int j = 0; j < 64; j++) begin
            n_cmp++; if (obs_w[j] !== ref_w[j] || obs_wp[j] !== (ref_w[j] ^ ref_w[j+4])) begin
                n_fail++; $display("[TB] FAIL ones[%0d]: got %h/%h, want %h/%h", j, obs_w[j], obs_wp[j], ref_w[j], ref_w[j] ^ ref_w[j+4]);
            end
        end
    endtask

    task automatic test_hold_last();
        bit acc;
        compute_ref(abc_blk);
        bus.w_ready_i = 1'b1;
        send_block(abc_blk, acc);
        repeat (63) step();
        n_cmp++; if (bus.round_o !== 6'd63 || bus.last_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL hold_reach63: got round=%0d last=%b, want 63 1", bus.round_o, bus.last_o);
        end
        bus.w_ready_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_cmp++; if (bus.last_o !== 1'b1 || bus.w_valid_o !== 1'b1 || bus.blk_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                n_fail++; $display("[TB] FAIL hold_status[%0d]: got last=%b valid=%b ready=%b busy=%b, want 1 1 0 1", i, bus.last_o, bus.w_valid_o, bus.blk_ready_o, bus.busy_o);
            end
            n_cmp++; if (bus.round_o !== 6'd63 || bus.w_o !== ref_w[63] || bus.wp_o !== (ref_w[63] ^ ref_w[67])) begin
                n_fail++; $display("[TB] FAIL hold_words[%0d]: got r=%0d %h/%h, want r=63 %h/%h", i, bus.round_o, bus.w_o, bus.wp_o, ref_w[63], ref_w[63] ^ ref_w[67]);
            end
        end
        bus.w_ready_i = 1'b1;
        step();
        n_cmp++; if (bus.blk_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.w_valid_o !== 1'b0 || bus.last_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL hold_release: got ready=%b busy=%b valid=%b last=%b, want 1 0 0 0", bus.blk_ready_o, bus.busy_o, bus.w_valid_o, bus.last_o);
        end
    endtask

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        test_reset();
        test_abc();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_zeros_ones();
        test_hold_last();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
